button_counter_bank: RTL
========================

Name: button_counter_bank

Overview:
- Multi-channel, parametrised up/down/shift/clear counter bank. It sits directly downstream of the debounced button pulses and levels from button_parser.
- The successor to the single 4-bit LED counter. Adds:
  - N independently addressed channels
  - a selectable wrap or saturate arithmetic mode
  - a hold-to-auto-repeat state machine for increment and decrement
- The selected channel's value drives LEDs. All channel values are exported for display or debug.

Parameters:
- WIDTH, 4: bit width of each counter channel (>=2).
- CHANNELS, 2: number of counter channels (>=2).
- SAT_MODE, 0: 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec saturate at all-ones/zero.
- REPEAT_DELAY, 8: cycles a held level must persist before the first auto-repeat step (>=1).
- REPEAT_PERIOD, 4: cycles between successive auto-repeat steps (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- inc_pulse  input  1  one-cycle increment request (debounced pulse).
- dec_pulse  input  1  one-cycle decrement request.
- shl_pulse  input  1  one-cycle shift-left request.
- clr_pulse  input  1  one-cycle clear request.
- inc_held  input  1  debounced level; high while the increment button is held.
- dec_held  input  1  debounced level; high while the decrement button is held.
- sel  input  $clog2(CHANNELS)  channel addressed by all operations.
- count_sel  output  WIDTH  current value of channel sel (combinational mux of registers).
- counts  output  CHANNELS*WIDTH  all channel values; channel k at bits [k*WIDTH +: WIDTH].
- at_max  output  1  count_sel == all-ones.
- at_zero  output  1  count_sel == 0.

Behaviour:
- Reset (async, rst high):
  - all channels = 0; repeat FSM = IDLE; repeat timer = 0
  - count_sel = 0, at_zero = 1, at_max = 0 while rst is asserted and after release
- Only channel sel changes in a cycle; all other channels hold.
- Latency: an operation sampled at edge N is visible on counts/count_sel after edge N.
- Explicit-op priority when several pulses are high in one cycle: inc > dec > shl > clr. Exactly one op is applied per cycle.
- Arithmetic:
  - inc: v+1. At all-ones: wraps to 0 (SAT_MODE=0) or holds all-ones (SAT_MODE=1).
  - dec: v-1. At 0: wraps to all-ones (SAT_MODE=0) or holds 0 (SAT_MODE=1).
  - shl: {v[WIDTH-2:0],1'b0}. MSB is discarded and zero filled in both modes.
  - clr: v = 0.
- Auto-repeat FSM, states IDLE / DELAY / REPEAT; dir register latches the repeat direction (inc or dec):
  - IDLE: if inc_held, set dir=inc; else if dec_held, set dir=dec. Either way load timer=REPEAT_DELAY-1 and go to DELAY. Otherwise stay in IDLE.
  - DELAY: if the held level for dir is low, go to IDLE. Else if timer==0, emit a repeat step, load timer=REPEAT_PERIOD-1 and go to REPEAT. Else decrement timer.
  - REPEAT: if the held level for dir is low, go to IDLE. Else if timer==0, emit a repeat step and reload REPEAT_PERIOD-1. Else decrement timer.
  - A repeat step applies inc or dec (per dir) to the current sel with the same arithmetic rules.
  - The opposite held level is ignored until return to IDLE.
- Collisions and mid-operation events:
  - Repeat step and explicit pulse in the same cycle: the explicit op is applied and the repeat step is dropped. The FSM timer still reloads.
  - sel changing mid-repeat: subsequent steps apply to the new sel; no FSM restart.
  - rst mid-repeat: immediate return to IDLE with all channels 0. Held levels must fall and re-rise, or persist a full REPEAT_DELAY after release, before the next step.
- Timing: the initial pulse from button_parser gives the first step. With held=1 at edge 0 (IDLE→DELAY), the first repeat step takes effect at edge REPEAT_DELAY+1. Subsequent steps follow every REPEAT_PERIOD edges.
- at_max and at_zero are combinational from count_sel; no extra latency.

Test Plan:
All scenarios use WIDTH=4, CHANNELS=2, REPEAT_DELAY=8, REPEAT_PERIOD=4.
- Reset and basic ops: rst pulse; sel=0; inc ×3, shl ×1, dec ×1 → ch0 = 1,2,3,6,5; ch1 stays 0; at_zero=0 after first inc.
- Wrap vs saturate: SAT_MODE=0, ch0=15, inc → 0, then dec → 15. SAT_MODE=1, ch0=15, inc → 15 (at_max=1); ch0=0, dec → 0 (at_zero=1).
- Priority and shift: ch0=9, inc+dec+shl+clr pulsed together → 10. Then shl → 4 (MSB dropped). Then clr alone → 0.
- Auto-repeat: ch1, inc_held high 20 cycles with no pulses → steps at edges 9, 13, 17 → ch1 = 3. Drop held → IDLE, no further change. A dec_held overlapping an active inc repeat causes no decrement.
- Collision and sel switch: during REPEAT with dir=inc, assert dec_pulse on the step cycle → net −1 that cycle. Switch sel mid-repeat → the next step lands on the new channel.
- Async reset mid-repeat: assert rst between clock edges while in REPEAT → counts=0 immediately with no clock edge. After release with inc_held still high, the first step occurs REPEAT_DELAY+1 edges later.

Source files
------------

// File: rtl/button_counter_bank_if.sv
// Control/status bundle for button_counter_bank: button pulses and levels in,
// channel values and flags out.
interface button_counter_bank_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2
);
    localparam int SW = $clog2(CHANNELS);

    logic                      inc_pulse;
    logic                      dec_pulse;
    logic                      shl_pulse;
    logic                      clr_pulse;
    logic                      inc_held;
    logic                      dec_held;
    logic [SW-1:0]             sel;
    logic [WIDTH-1:0]          count_sel;
    logic [CHANNELS*WIDTH-1:0] counts;
    logic                      at_max;
    logic                      at_zero;

    modport master (
        output inc_pulse, dec_pulse, shl_pulse, clr_pulse,
        output inc_held, dec_held, sel,
        input  count_sel, counts, at_max, at_zero
    );

    modport slave (
        input  inc_pulse, dec_pulse, shl_pulse, clr_pulse,
        input  inc_held, dec_held, sel,
        output count_sel, counts, at_max, at_zero
    );
endinterface

// File: rtl/button_counter_bank.sv
// Multi-channel up/down/shift/clear counter bank with wrap or saturate
// arithmetic and a hold-to-auto-repeat engine for increment/decrement.
module button_counter_bank #(
    parameter int WIDTH         = 4,
    parameter int CHANNELS      = 2,
    parameter int SAT_MODE      = 0,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    button_counter_bank_if.slave ctl_if
);
    localparam int SW   = $clog2(CHANNELS);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0]    T_DLY = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]    T_PER = TW'(REPEAT_PERIOD - 1);
    localparam logic [WIDTH-1:0] ONES  = '1;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             step_q, step_d;
    logic [WIDTH-1:0] cnt_q [CHANNELS];
    logic [WIDTH-1:0] cnt_d [CHANNELS];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic             wr;
    logic             held_dir;

    function automatic logic [WIDTH-1:0] inc_v(input logic [WIDTH-1:0] v);
        if (SAT_MODE != 0 && v == ONES) return v;
        return v + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] dec_v(input logic [WIDTH-1:0] v);
        if (SAT_MODE != 0 && v == '0) return v;
        return v - 1'b1;
    endfunction

    assign held_dir = dir_q ? ctl_if.inc_held : ctl_if.dec_held;

    // A step is emitted into step_q and applied on the following edge.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        step_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ctl_if.inc_held || ctl_if.dec_held) begin
                    dir_d   = ctl_if.inc_held;
                    timer_d = T_DLY;
                    state_d = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!held_dir) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    step_d  = 1'b1;
                    timer_d = T_PER;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ctl_if.sel == SW'(k)) cur = cnt_q[k];
        end
    end

    // Explicit pulses outrank a pending repeat step, which is then dropped.
    always_comb begin
        wr  = 1'b1;
        nxt = cur;
        priority case (1'b1)
            ctl_if.inc_pulse: nxt = inc_v(cur);
            ctl_if.dec_pulse: nxt = dec_v(cur);
            ctl_if.shl_pulse: nxt = {cur[WIDTH-2:0], 1'b0};
            ctl_if.clr_pulse: nxt = '0;
            step_q:           nxt = dir_q ? inc_v(cur) : dec_v(cur);
            default:          wr  = 1'b0;
        endcase
    end

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (wr && ctl_if.sel == SW'(k)) cnt_d[k] = nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            timer_q <= '0;
            step_q  <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) cnt_q[k] <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            step_q  <= step_d;
            for (int k = 0; k < CHANNELS; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_pack
        assign ctl_if.counts[k*WIDTH +: WIDTH] = cnt_q[k];
    end

    assign ctl_if.count_sel = cur;
    assign ctl_if.at_max    = (cur == ONES);
    assign ctl_if.at_zero   = (cur == '0);
endmodule
